// File: rtl/jesd204_rx_sh_lock_64b_if.sv
// rtl/jesd204_rx_sh_lock_64b_if.sv - block stream from gearbox and registered stream to descrambler
interface jesd204_rx_sh_lock_64b_if;
    logic        in_valid;
    logic [1:0]  in_header;
    logic [63:0] in_data;
    logic        out_valid;
    logic [1:0]  out_header;
    logic [63:0] out_data;

    // master: gearbox/descrambler side; slave: the lock stage
    modport master (
        output in_valid, in_header, in_data,
        input  out_valid, out_header, out_data
    );
    modport slave (
        input  in_valid, in_header, in_data,
        output out_valid, out_header, out_data
    );
endinterface

// File: rtl/jesd204_rx_sh_lock_64b.sv
// rtl/jesd204_rx_sh_lock_64b.sv - 64b/66b sync-header lock FSM with bitslip requests and registered passthrough
module jesd204_rx_sh_lock_64b #(
    parameter int LOCK_CNT   = 64,
    parameter int ERR_WINDOW = 64,
    parameter int ERR_THRESH = 16,
    parameter int SLIP_WAIT  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    jesd204_rx_sh_lock_64b_if.slave       blk,
    output logic                          sh_lock,
    output logic                          slip,
    output logic [7:0]                    err_count
);
    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT);
    localparam logic [7:0] WINDOW_LAST = 8'(ERR_WINDOW);
    localparam logic [7:0] THRESH_LAST = 8'(ERR_THRESH);
    localparam logic [7:0] WAIT_LAST   = 8'(SLIP_WAIT);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t     state;
    logic [7:0] good_cnt;
    logic [7:0] wait_cnt;
    logic [7:0] win_cnt;
    logic [7:0] win_err;

    logic       hdr_ok;
    logic [7:0] good_nxt;
    logic [7:0] wait_nxt;
    logic [7:0] win_nxt;
    logic [7:0] err_nxt;

    always_comb begin
        hdr_ok   = blk.in_header[1] ^ blk.in_header[0];
        good_nxt = good_cnt + 8'd1;
        wait_nxt = wait_cnt + 8'd1;
        win_nxt  = win_cnt + 8'd1;
        err_nxt  = win_err + {7'd0, ~hdr_ok};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk.out_valid  <= 1'b0;
            blk.out_header <= 2'b00;
            blk.out_data   <= 64'd0;
            state          <= ST_HUNT;
            good_cnt       <= 8'd0;
            wait_cnt       <= 8'd0;
            win_cnt        <= 8'd0;
            win_err        <= 8'd0;
            sh_lock        <= 1'b0;
            slip           <= 1'b0;
            err_count      <= 8'd0;
        end else begin
            blk.out_valid  <= blk.in_valid;
            blk.out_header <= blk.in_header;
            blk.out_data   <= blk.in_data;
            slip           <= 1'b0;

            if (!enable) begin
                state    <= ST_HUNT;
                good_cnt <= 8'd0;
                sh_lock  <= 1'b0;
            end else if (blk.in_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (hdr_ok) begin
                            if (good_nxt == LOCK_LAST) begin
                                state     <= ST_LOCKED;
                                sh_lock   <= 1'b1;
                                good_cnt  <= 8'd0;
                                err_count <= 8'd0;
                                win_cnt   <= 8'd0;
                                win_err   <= 8'd0;
                            end else begin
                                good_cnt <= good_nxt;
                            end
                        end else begin
                            slip     <= 1'b1;
                            good_cnt <= 8'd0;
                            wait_cnt <= 8'd0;
                            state    <= ST_SLIP_WAIT;
                        end
                    end
                    ST_SLIP_WAIT: begin
                        // headers are meaningless while the gearbox settles
                        if (wait_nxt == WAIT_LAST) begin
                            state    <= ST_HUNT;
                            good_cnt <= 8'd0;
                            wait_cnt <= 8'd0;
                        end else begin
                            wait_cnt <= wait_nxt;
                        end
                    end
                    ST_LOCKED: begin
                        if (!hdr_ok && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        // loss of lock takes priority over window rollover
                        if (err_nxt == THRESH_LAST) begin
                            state    <= ST_HUNT;
                            sh_lock  <= 1'b0;
                            good_cnt <= 8'd0;
                            win_cnt  <= 8'd0;
                            win_err  <= 8'd0;
                        end else if (win_nxt == WINDOW_LAST) begin
                            win_cnt <= 8'd0;
                            win_err <= 8'd0;
                        end else begin
                            win_cnt <= win_nxt;
                            win_err <= err_nxt;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jesd204_rx_sh_lock_64b.sv
// tb/tb_jesd204_rx_sh_lock_64b.sv - directed self-checking bench for the sync-header lock stage
module tb_jesd204_rx_sh_lock_64b;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b1;
    logic       sh_lock;
    logic       slip;
    logic [7:0] err_count;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         slip_cnt = 0;

    jesd204_rx_sh_lock_64b_if bus ();

    jesd204_rx_sh_lock_64b dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .blk       (bus),
        .sh_lock   (sh_lock),
        .slip      (slip),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (slip === 1'b1) slip_cnt++;

    task automatic blk(input logic v, input logic [1:0] h, input logic [63:0] d);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_header = h;
        bus.in_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_header = 2'b11; bus.in_data = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0h want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_header !== 2'b00) $display("FAIL reset_out_header: got %0h want 0", bus.out_header); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 64'd0) $display("FAIL reset_out_data: got %0h want 0", bus.out_data); else pass_cnt++;
        total_cnt++; if (sh_lock !== 1'b0) $display("FAIL reset_sh_lock: got %0h want 0", sh_lock); else pass_cnt++;
        total_cnt++; if (slip !== 1'b0) $display("FAIL reset_slip: got %0h want 0", slip); else pass_cnt++;
        total_cnt++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0h want 0", err_count); else pass_cnt++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_lock_basic();
        logic [63:0] d;
        int base = slip_cnt;
        for (int i = 1; i <= 64; i++) begin
            d = {$urandom(), $urandom()};
            blk(1'b1, 2'b01, d);
            total_cnt++; if (bus.out_data !== d || bus.out_header !== 2'b01 || bus.out_valid !== 1'b1)
                $display("FAIL basic_datapath[%0d]: got %0h/%0h want %0h/1", i, bus.out_data, bus.out_header, d); else pass_cnt++;
            if (i == 63) begin
                total_cnt++; if (sh_lock !== 1'b0) $display("FAIL basic_lock_early: got %0h want 0", sh_lock); else pass_cnt++;
            end
        end
        total_cnt++; if (sh_lock !== 1'b1) $display("FAIL basic_lock: got %0h want 1", sh_lock); else pass_cnt++;
        total_cnt++; if (slip_cnt - base !== 0) $display("FAIL basic_no_slip: got %0d want 0", slip_cnt - base); else pass_cnt++;
        total_cnt++; if (err_count !== 8'd0) $display("FAIL basic_err_count: got %0d want 0", err_count); else pass_cnt++;
    endtask

    task automatic test_slip();
        int base;
        reset_pulse();
        base = slip_cnt;
        for (int i = 0; i < 10; i++) blk(1'b1, 2'b10, 64'(i));
        blk(1'b1, 2'b11, 64'hBAD);
        total_cnt++; if (slip !== 1'b1) $display("FAIL slip_pulse: got %0h want 1", slip); else pass_cnt++;
        for (int i = 0; i < 8; i++) blk(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 64'(i));
        total_cnt++; if (slip_cnt - base !== 1) $display("FAIL slip_once: got %0d want 1", slip_cnt - base); else pass_cnt++;
        for (int i = 0; i < 63; i++) blk(1'b1, 2'b01, 64'(i));
        total_cnt++; if (sh_lock !== 1'b0) $display("FAIL slip_lock_early: got %0h want 0", sh_lock); else pass_cnt++;
        blk(1'b1, 2'b01, 64'h64);
        total_cnt++; if (sh_lock !== 1'b1) $display("FAIL slip_relock: got %0h want 1", sh_lock); else pass_cnt++;
    endtask

    task automatic test_err_window();
        int base = slip_cnt;
        for (int w = 1; w <= 2; w++) begin
            for (int i = 0; i < 64; i++)
                blk(1'b1, (i % 4 == 0 && i < 60) ? 2'b00 : 2'b01, 64'(i));
            total_cnt++; if (sh_lock !== 1'b1) $display("FAIL window%0d_lock: got %0h want 1", w, sh_lock); else pass_cnt++;
            total_cnt++; if (err_count !== 8'(15 * w)) $display("FAIL window%0d_err_count: got %0d want %0d", w, err_count, 15 * w); else pass_cnt++;
        end
        total_cnt++; if (slip_cnt - base !== 0) $display("FAIL window_no_slip: got %0d want 0", slip_cnt - base); else pass_cnt++;
    endtask

    task automatic test_loss();
        int base = slip_cnt;
        for (int i = 0; i < 63; i++)
            blk(1'b1, (i % 4 == 0 && i < 60) ? 2'b11 : 2'b10, 64'(i));
        total_cnt++; if (sh_lock !== 1'b1 || err_count !== 8'd45) $display("FAIL loss_before: got %0h/%0d want 1/45", sh_lock, err_count); else pass_cnt++;
        blk(1'b1, 2'b00, 64'h63);
        total_cnt++; if (sh_lock !== 1'b0) $display("FAIL loss_unlock: got %0h want 0", sh_lock); else pass_cnt++;
        total_cnt++; if (err_count !== 8'd46) $display("FAIL loss_err_count: got %0d want 46", err_count); else pass_cnt++;
        for (int i = 0; i < 64; i++) blk(1'b1, 2'b01, 64'(i));
        total_cnt++; if (slip_cnt - base !== 0) $display("FAIL loss_no_slip: got %0d want 0", slip_cnt - base); else pass_cnt++;
        total_cnt++; if (sh_lock !== 1'b1 || err_count !== 8'd0) $display("FAIL loss_rehunt: got %0h/%0d want 1/0", sh_lock, err_count); else pass_cnt++;
    endtask

    task automatic test_toggle();
        int base;
        reset_pulse();
        base = slip_cnt;
        for (int i = 1; i <= 64; i++) begin
            blk(1'b1, 2'b10, 64'(i));
            if (i == 63) begin
                total_cnt++; if (sh_lock !== 1'b0) $display("FAIL toggle_lock_early: got %0h want 0", sh_lock); else pass_cnt++;
            end
            if (i < 64) begin
                blk(1'b0, 2'b11, 64'hDEAD);
                if (i == 1) begin
                    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL toggle_out_valid: got %0h want 0", bus.out_valid); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (sh_lock !== 1'b1) $display("FAIL toggle_lock: got %0h want 1", sh_lock); else pass_cnt++;
        total_cnt++; if (slip_cnt - base !== 0) $display("FAIL toggle_no_slip: got %0d want 0", slip_cnt - base); else pass_cnt++;
    endtask

    task automatic test_enable();
        enable = 1'b0;
        blk(1'b1, 2'b01, 64'h1);
        total_cnt++; if (sh_lock !== 1'b0) $display("FAIL enable_drop: got %0h want 0", sh_lock); else pass_cnt++;
        enable = 1'b1;
        for (int i = 0; i < 63; i++) blk(1'b1, 2'b01, 64'(i));
        total_cnt++; if (sh_lock !== 1'b0) $display("FAIL enable_lock_early: got %0h want 0", sh_lock); else pass_cnt++;
        blk(1'b1, 2'b01, 64'h2);
        total_cnt++; if (sh_lock !== 1'b1) $display("FAIL enable_relock: got %0h want 1", sh_lock); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        enable = 1'b0;
        blk(1'b1, 2'b01, 64'h1);
        enable = 1'b1;
        blk(1'b1, 2'b11, 64'h5A5A);
        total_cnt++; if (slip !== 1'b1) $display("FAIL mid_slip: got %0h want 1", slip); else pass_cnt++;
        bus.in_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        total_cnt++; if (slip !== 1'b0 || sh_lock !== 1'b0 || err_count !== 8'd0)
            $display("FAIL mid_reset_status: got %0h/%0h/%0d want 0/0/0", slip, sh_lock, err_count); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b0 || bus.out_header !== 2'b00 || bus.out_data !== 64'd0)
            $display("FAIL mid_reset_data: got %0h/%0h/%0h want 0/0/0", bus.out_valid, bus.out_header, bus.out_data); else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 63; i++) blk(1'b1, 2'b10, 64'(i));
        total_cnt++; if (sh_lock !== 1'b0) $display("FAIL mid_lock_early: got %0h want 0", sh_lock); else pass_cnt++;
        blk(1'b1, 2'b10, 64'h3);
        total_cnt++; if (sh_lock !== 1'b1) $display("FAIL mid_relock: got %0h want 1", sh_lock); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_slip();
        test_err_window();
        test_loss();
        test_toggle();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
